unpack_scale_p: RTL
===================

# unpack_scale_p

Decodes a densely packed mod-p polynomial vector (10-bit coefficients, bit-contiguous across 64-bit words) back into the coprocessor's lane format (four 16-bit lanes per 64-bit word) and scales each coefficient by 2^(EQ−EP) into the mod-q domain. It is the inverse of the add-round-and-pack step. Typical use is unpacking ciphertext vector b' before polynomial arithmetic in decryption. It runs autonomously from reset release, reading one data memory region and writing another.

## Interface
- NUM_BLOCKS, 24, number of 320-bit blocks processed; each block is 5 read words and 8 written words. The default covers 3×256 coefficients: 120 reads, 192 writes.
- LSHIFT, 3, left shift applied to each 10-bit coefficient (EQ−EP); 10+LSHIFT ≤ 16.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- read_address  out  9  packed-input word address; starts at 0.
- read_data  in  64  memory data, valid one cycle after read_address is presented (synchronous RAM).
- write_address  out  9  lane-format output word address; starts at 0.
- write_data  out  64  output word, combinational from the buffer.
- write_en  out  1  write strobe; one word per high cycle.
- done  out  1  high and held once all blocks are written.

## Operation
- 320-bit buffer. Two shift modes:
  - Capture: buffer ← {read_data, buffer[319:64]}. After 5 captures, input word 0 sits at buffer[63:0].
  - Emit: buffer ← {40'd0, buffer[319:40]}.
- write_data lane k (bits 16k+15:16k), k=0..3, = zero-extended buffer[10k+9:10k] << LSHIFT. With LSHIFT=3 each lane is {3'b000, c[9:0], 3'b000}. No rounding and no sign handling.
- Coefficients straddling word boundaries (coefficient 6 uses word0[63:60] and word1[5:0], etc.) are reassembled by the buffer shifting alone.
- FSM states and actions:
  - INIT: idle for one cycle.
  - R0: issue read only.
  - R1–R4: issue read and capture.
  - R5: capture only.
  - W0–W7: emit, write_en=1.
  - DONE: hold.
- Transitions are sequential INIT→R0→…→R5→W0→…→W7.
- At W7: if read_address == 5·NUM_BLOCKS, go to DONE; otherwise go to R0.
- read_address increments in R0–R4. write_address increments on every cycle with write_en=1.
- Addresses are not reset per block. They run contiguously 0..5·NUM_BLOCKS−1 and 0..8·NUM_BLOCKS−1.
- DONE is absorbing. Only rst leaves it: no further reads, no writes, addresses frozen.

## Timing
- Reset values: state INIT, read_address 0, write_address 0, write_en 0, done 0. Buffer contents are don't-care; write_data is don't-care while write_en=0.
- Reset mid-operation: the next cycle returns to INIT with both addresses 0. A write in flight on the reset cycle is not committed.
- Per block: 14 cycles (6 read, 8 write).
- First write_en is at cycle 7 after rst deasserts (INIT=cycle 0).
- done rises at cycle 1+14·NUM_BLOCKS (337 for the default).
- No stall or backpressure input exists. The memory must accept one write per cycle and return data with exactly one cycle of latency.
- Read and write phases never overlap, so shared single-port memory works if the regions are disjoint.

## Structure
- Shared Saber package holds:
  - constants: COEFF_P_W=10, LANE_W=16, WORD_W=64, BLOCK_READS=5, BLOCK_WRITES=8, EQ_MINUS_EP=3;
  - the FSM state enum.
- One natural sub-module: p2q_lane_expand, combinational 40-bit → 64-bit lane expander parameterised by LSHIFT. It is reusable by other unpackers.
- Counters, buffer and FSM live in the top.

## Test plan
- Lane 0 expansion: word0=64'h0000_0000_0000_03FF, words 1–4 zero → first write at address 0 is 64'h0000_0000_0000_1FF8; writes 1–7 of the block are 0.
- Boundary straddle: word0=64'hF000_0000_0000_0000, word1=64'h0000_0000_0000_003F, others 0 → write address 1 data 64'h0000_1FF8_0000_0000; all other writes 0.
- Full run with a random packed image of 120 words → 192 writes, addresses 0..191 contiguous, each lane equal to the golden unpack<<3. Round-trip against the add-round model: packing then unpacking yields (c+4)>>3<<3.
- Cycle count: after rst release, write_en first high at cycle 7; exactly 8 consecutive writes per block; done high at cycle 337; read_address stays 120 and write_address stays 192 afterwards.
- Reset mid-run: assert rst during the W3 of block 5 → next cycle both addresses 0, write_en 0. The full sequence restarts and completes at 337 cycles after the new release.
- Parameter NUM_BLOCKS=1, LSHIFT=0 → 5 reads, 8 writes, lanes equal the raw 10-bit values, done at cycle 15.

Source files
------------

// File: rtl/unpack_scale_p_pkg.sv
// -----------------------------------------------------------------------------
// unpack_scale_p_pkg
// Shared constants and FSM state type for the mod-p to mod-q unpacker.
//   COEFF_P_W    width of a packed mod-p coefficient
//   LANE_W       width of one coprocessor lane
//   WORD_W       memory word width
//   BLOCK_READS  packed words consumed per 320-bit block
//   BLOCK_WRITES lane-format words produced per block
//   EQ_MINUS_EP  default scaling shift into the mod-q domain
// -----------------------------------------------------------------------------
package unpack_scale_p_pkg;

  localparam int COEFF_P_W    = 10;
  localparam int LANE_W       = 16;
  localparam int WORD_W       = 64;
  localparam int BLOCK_READS  = 5;
  localparam int BLOCK_WRITES = 8;
  localparam int EQ_MINUS_EP  = 3;

  // Packed bits per block and coefficients consumed by one emitted word.
  localparam int BUF_W     = BLOCK_READS * WORD_W;
  localparam int EMIT_W    = (WORD_W / LANE_W) * COEFF_P_W;

  // Sequencer states: one idle cycle, six read cycles, eight write cycles.
  typedef enum logic [3:0] {
    ST_INIT = 4'd0,
    ST_R0   = 4'd1,
    ST_R1   = 4'd2,
    ST_R2   = 4'd3,
    ST_R3   = 4'd4,
    ST_R4   = 4'd5,
    ST_R5   = 4'd6,
    ST_W0   = 4'd7,
    ST_W1   = 4'd8,
    ST_W2   = 4'd9,
    ST_W3   = 4'd10,
    ST_W4   = 4'd11,
    ST_W5   = 4'd12,
    ST_W6   = 4'd13,
    ST_W7   = 4'd14,
    ST_DONE = 4'd15
  } state_t;

  // True in the states that shift read data into the buffer.
  function automatic logic is_capture_state(input state_t s);
    logic r;
    case (s)
      ST_R1, ST_R2, ST_R3, ST_R4, ST_R5: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  // True in the states that emit one lane-format word.
  function automatic logic is_write_state(input state_t s);
    logic r;
    case (s)
      ST_W0, ST_W1, ST_W2, ST_W3,
      ST_W4, ST_W5, ST_W6, ST_W7: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/unpack_scale_p_p2q_lane_expand.sv
// -----------------------------------------------------------------------------
// p2q_lane_expand
// Combinational expander: four packed 10-bit mod-p coefficients become four
// 16-bit lanes, each zero-extended and shifted left by LSHIFT (EQ-EP).
//   coeffs  in  40  coefficient k at bits [10k+9:10k]
//   lanes   out 64  lane k at bits [16k+15:16k]
// -----------------------------------------------------------------------------
module p2q_lane_expand
  import unpack_scale_p_pkg::*;
#(
  parameter int LSHIFT = EQ_MINUS_EP
) (
  input  logic [EMIT_W-1:0] coeffs,
  output logic [WORD_W-1:0] lanes
);

  localparam int NUM_LANES = WORD_W / LANE_W;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [LANE_W-1:0] wide;

    // No rounding and no sign handling: a pure scale into the mod-q range.
    assign wide = {{(LANE_W - COEFF_P_W){1'b0}}, coeffs[k*COEFF_P_W +: COEFF_P_W]};
    assign lanes[k*LANE_W +: LANE_W] = wide << LSHIFT;
  end

endmodule

// File: rtl/unpack_scale_p.sv
// -----------------------------------------------------------------------------
// unpack_scale_p
// Autonomous unpacker: reads a bit-contiguous stream of 10-bit mod-p
// coefficients (five 64-bit words per block) and writes them out as four
// 16-bit lanes per word (eight words per block), scaled by 2^LSHIFT.
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous active-high reset
//   read_address   out  9   packed word address, runs 0..5*NUM_BLOCKS-1
//   read_data      in   64  memory data, one cycle after read_address
//   write_address  out  9   lane word address, runs 0..8*NUM_BLOCKS-1
//   write_data     out  64  lane-format word (valid while write_en)
//   write_en       out  1   one word written per high cycle
//   done           out  1   held high once every block is written
// -----------------------------------------------------------------------------
module unpack_scale_p
  import unpack_scale_p_pkg::*;
#(
  parameter int NUM_BLOCKS = 24,
  parameter int LSHIFT     = EQ_MINUS_EP
) (
  input  logic              clk,
  input  logic              rst,
  output logic [8:0]        read_address,
  input  logic [WORD_W-1:0] read_data,
  output logic [8:0]        write_address,
  output logic [WORD_W-1:0] write_data,
  output logic              write_en,
  output logic              done
);

  // read_address equals this value after the final block's reads are issued.
  localparam logic [8:0] LAST_READ = 9'(BLOCK_READS * NUM_BLOCKS);

  state_t             state;
  logic [BUF_W-1:0]   buffer;
  logic               write_en_q;

  // Sequencer: state, address counters and the registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT;
      read_address  <= 9'd0;
      write_address <= 9'd0;
      write_en_q    <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (write_en_q) begin
        write_address <= write_address + 9'd1;
      end else begin
        write_address <= write_address;
      end

      case (state)
        ST_INIT: begin
          state <= ST_R0;
        end
        ST_R0: begin
          read_address <= read_address + 9'd1;
          state        <= ST_R1;
        end
        ST_R1: begin
          read_address <= read_address + 9'd1;
          state        <= ST_R2;
        end
        ST_R2: begin
          read_address <= read_address + 9'd1;
          state        <= ST_R3;
        end
        ST_R3: begin
          read_address <= read_address + 9'd1;
          state        <= ST_R4;
        end
        ST_R4: begin
          read_address <= read_address + 9'd1;
          state        <= ST_R5;
        end
        ST_R5: begin
          // Last capture lands this cycle; the strobe is registered so it
          // is already high when W0 begins.
          write_en_q <= 1'b1;
          state      <= ST_W0;
        end
        ST_W0: state <= ST_W1;
        ST_W1: state <= ST_W2;
        ST_W2: state <= ST_W3;
        ST_W3: state <= ST_W4;
        ST_W4: state <= ST_W5;
        ST_W5: state <= ST_W6;
        ST_W6: state <= ST_W7;
        ST_W7: begin
          write_en_q <= 1'b0;
          if (read_address == LAST_READ) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_R0;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: begin
          state      <= ST_INIT;
          write_en_q <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  // Data buffer: words enter at the top, coefficients leave from the bottom.
  // Its contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (is_capture_state(state)) begin
      buffer <= {read_data, buffer[BUF_W-1:WORD_W]};
    end else if (is_write_state(state)) begin
      buffer <= {{EMIT_W{1'b0}}, buffer[BUF_W-1:EMIT_W]};
    end else begin
      buffer <= buffer;
    end
  end

  p2q_lane_expand #(
    .LSHIFT (LSHIFT)
  ) u_expand (
    .coeffs (buffer[EMIT_W-1:0]),
    .lanes  (write_data)
  );

  // A write still in flight when rst is sampled must not reach memory.
  assign write_en = write_en_q & ~rst;

endmodule
